ucsbece154b_branch_predictor: RTL

Parametrised gshare direction predictor plus direct-mapped BTB for the 5-stage ucsbece154b RISC-V pipeline. Replaces the fixed predict-not-taken scheme behind the pipeline's mispredict signal. Fetch-stage lookup is combinational on PCF. Training is done from execute-stage resolution one clock later. The global history register (GHR) is non-speculative and is updated only at resolution.

---
 rtl/ucsbece154b_bp_pkg.sv | 35 +++
 rtl/ucsbece154b_btb.sv | 68 ++++++
 rtl/ucsbece154b_branch_predictor.sv | 103 ++++++++++
 3 files changed

// File: rtl/ucsbece154b_bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154b_bp_pkg
// Description : Shared PHT state encodings and helpers for the gshare/BTB
//               branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package ucsbece154b_bp_pkg;

  localparam logic [1:0] c_pht_sn    = 2'b00;
  localparam logic [1:0] c_pht_wn    = 2'b01;
  localparam logic [1:0] c_pht_wt    = 2'b10;
  localparam logic [1:0] c_pht_st    = 2'b11;
  localparam logic [1:0] c_pht_reset = c_pht_wn;

  // Ceiling log2; exact for the power-of-two sizes used here.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  // Saturating 2-bit counter step.
  function automatic logic [1:0] pht_next(input logic [1:0] state, input logic taken);
    logic [1:0] nxt;
    if (taken) nxt = (state == c_pht_st) ? c_pht_st : state + 2'b01;
    else       nxt = (state == c_pht_sn) ? c_pht_sn : state - 2'b01;
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ucsbece154b_btb.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154b_btb
// Description : Direct-mapped branch target buffer with combinational lookup
//               and a single synchronous write port.
// Revision    : 1.0 - initial release
// ============================================================================
module ucsbece154b_btb
  import ucsbece154b_bp_pkg::*;
#(
  parameter int NUM_ENTRIES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_lookup_pc,
  output logic        o_hit,
  output logic [31:0] o_target,
  output logic        o_is_jump,
  input  logic        i_we,
  input  logic [31:0] i_wr_pc,
  input  logic [31:0] i_wr_target,
  input  logic        i_wr_is_jump
);

  localparam int c_idx_w = clog2(NUM_ENTRIES);
  localparam int c_tag_w = 30 - c_idx_w;

  logic [NUM_ENTRIES-1:0] r_valid;
  logic [NUM_ENTRIES-1:0] r_is_jump;
  logic [c_tag_w-1:0]     r_tag    [NUM_ENTRIES];
  logic [31:0]            r_target [NUM_ENTRIES];

  logic [c_idx_w-1:0] w_rd_idx;
  logic [c_idx_w-1:0] w_wr_idx;
  logic [c_tag_w-1:0] w_rd_tag;
  logic [c_tag_w-1:0] w_wr_tag;
  logic               w_unused_pc_bits;

  assign w_rd_idx = i_lookup_pc[c_idx_w+1:2];
  assign w_rd_tag = i_lookup_pc[31:c_idx_w+2];
  assign w_wr_idx = i_wr_pc[c_idx_w+1:2];
  assign w_wr_tag = i_wr_pc[31:c_idx_w+2];
  assign w_unused_pc_bits = ^{i_lookup_pc[1:0], i_wr_pc[1:0]};

  // Reads see pre-update contents; a write lands on the next cycle.
  assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_target  = o_hit ? r_target[w_rd_idx] : 32'h0;
  assign o_is_jump = r_is_jump[w_rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: a cleared valid bit masks stale contents.
  always_ff @(posedge clk) begin
    if (i_we && !reset) begin
      r_tag[w_wr_idx]     <= w_wr_tag;
      r_target[w_wr_idx]  <= i_wr_target;
      r_is_jump[w_wr_idx] <= i_wr_is_jump;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ucsbece154b_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154b_branch_predictor
// Description : gshare direction predictor plus direct-mapped BTB; optional
//               statistics counters enabled by UCSBECE154B_BP_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ucsbece154b_branch_predictor
  import ucsbece154b_bp_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             PCF_i,
  output logic                    PredictTakenF_o,
  output logic [31:0]             PredictTargetF_o,
  output logic [NUM_GHR_BITS-1:0] PHTIndexF_o,
  input  logic                    BranchE_i,
  input  logic                    JumpE_i,
  input  logic                    TakenE_i,
  input  logic [31:0]             PCE_i,
  input  logic [31:0]             TargetE_i,
  input  logic [NUM_GHR_BITS-1:0] PHTIndexE_i,
  input  logic                    MispredictE_i,
  output logic [31:0]             BranchCount_o,
  output logic [31:0]             MispredictCount_o
);

  localparam int c_pht_entries = 1 << NUM_GHR_BITS;

  logic [NUM_GHR_BITS-1:0] r_ghr;
  logic [1:0]              r_pht [c_pht_entries];

  logic        w_btb_hit;
  logic        w_btb_is_jump;
  logic [31:0] w_btb_target;
  logic        w_resolve;
  logic        w_is_branch;
  logic        w_btb_we;

  assign PHTIndexF_o      = PCF_i[NUM_GHR_BITS+1:2] ^ r_ghr;
  assign PredictTakenF_o  = w_btb_hit && (w_btb_is_jump || r_pht[PHTIndexF_o][1]);
  assign PredictTargetF_o = w_btb_target;

  // Branch and jump together is illegal; the jump interpretation wins.
  assign w_resolve   = BranchE_i || JumpE_i;
  assign w_is_branch = BranchE_i && !JumpE_i;
  assign w_btb_we    = w_resolve && TakenE_i;

  ucsbece154b_btb #(
    .NUM_ENTRIES (NUM_BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .reset        (reset),
    .i_lookup_pc  (PCF_i),
    .o_hit        (w_btb_hit),
    .o_target     (w_btb_target),
    .o_is_jump    (w_btb_is_jump),
    .i_we         (w_btb_we),
    .i_wr_pc      (PCE_i),
    .i_wr_target  (TargetE_i),
    .i_wr_is_jump (JumpE_i)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ghr <= '0;
      for (int i = 0; i < c_pht_entries; i++) begin
        r_pht[i] <= c_pht_reset;
      end
    end else if (w_is_branch) begin
      r_ghr              <= {r_ghr[NUM_GHR_BITS-2:0], TakenE_i};
      r_pht[PHTIndexE_i] <= pht_next(r_pht[PHTIndexE_i], TakenE_i);
    end
  end

`ifdef UCSBECE154B_BP_STATS_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_count     <= 32'h0;
      r_mispredict_count <= 32'h0;
    end else if (w_resolve) begin
      r_branch_count <= r_branch_count + 32'h1;
      if (MispredictE_i) r_mispredict_count <= r_mispredict_count + 32'h1;
    end
  end

  assign BranchCount_o     = r_branch_count;
  assign MispredictCount_o = r_mispredict_count;
`else
  logic w_unused_stats;
  assign w_unused_stats    = MispredictE_i;
  assign BranchCount_o     = 32'h0;
  assign MispredictCount_o = 32'h0;
`endif

endmodule
`default_nettype wire
